lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
- Parametrised synchronous LIFO stack; next generation of the processor's push/pop operand stack.
- Adds over the previous generation:
  - configurable width and depth
  - clocked operation with a registered pop output and valid strobe
  - full/empty/level status
  - sticky overflow/underflow error flags
  - simultaneous push+pop (replace-top)
  - synchronous flush
- Sits between the control unit (push/pop/flush) and the datapath (operand in, operand out).

Parameters:
WIDTH  16  data word width in bits
DEPTH  16  number of stack entries; any integer >= 2 (not restricted to powers of 2)
LW  $clog2(DEPTH+1)  derived, localparam; width of the level count

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk
push  input  1  push request for this cycle
pop  input  1  pop request for this cycle
flush  input  1  synchronous empty; discards all entries
din  input  WIDTH  data to push
dout  output  WIDTH  registered popped word
dout_valid  output  1  high for one cycle after an accepted pop
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  LW  number of valid entries, 0..DEPTH
ovf  output  1  sticky overflow flag: push attempted while full without pop
udf  output  1  sticky underflow flag: pop attempted while empty without push

Behaviour:
- Storage: mem[0..DEPTH-1]; level register counts entries; top of stack = mem[level-1]. Memory is not reset; its contents are unobservable when level == 0.
- Reset (rst_n low at edge): level=0, dout=0, dout_valid=0, ovf=0, udf=0. Highest priority; an in-flight push/pop in that cycle is discarded.
- flush (rst_n high): level=0, dout_valid=0, ovf=0, udf=0; dout holds its value; push/pop in the same cycle are ignored.
- Otherwise, evaluated per cycle (dout_valid defaults to 0 each cycle unless set below):
  - push only, not full: mem[level]<=din; level+1.
  - push only, full: no write; level unchanged; ovf<=1.
  - pop only, not empty: dout<=mem[level-1]; dout_valid<=1; level-1.
  - pop only, empty: dout unchanged; dout_valid stays 0; udf<=1.
  - push&pop, not empty (including full): dout<=old mem[level-1]; mem[level-1]<=din; level unchanged; dout_valid<=1; no ovf.
  - push&pop, empty: bypass; dout<=din; dout_valid<=1; level stays 0; no udf.
  - neither: hold all state.
- Latency: a popped word appears on dout with dout_valid one clock after the pop edge. A push is visible to a pop in the immediately following cycle.
- full, empty: combinational decodes of the level register only, never of push/pop inputs.
- ovf/udf: set-only; cleared only by reset or flush.
- level arithmetic is LW bits wide; it never wraps. Guards above keep it within 0..DEPTH.

Test Plan:
- Reset, then fill (WIDTH=16, DEPTH=4): push 0x1111, 0x2222, 0x3333, 0x4444 -> level=4, full=1, empty=0, ovf=0.
- Pop 4 times -> dout=0x4444, 0x3333, 0x2222, 0x1111, each with a 1-cycle dout_valid pulse one cycle after its pop; afterwards empty=1, level=0.
- Overflow/underflow: when full, push 0x5555 -> ovf=1, level=4, top still 0x4444. Flush -> level=0, ovf=0. Pop while empty -> udf=1, dout_valid=0, dout unchanged.
- Simultaneous: with stack [0xAAAA, 0xBBBB], push+pop din=0xCCCC -> dout=0xBBBB valid, level=2; next pop -> dout=0xCCCC. When empty, push+pop din=0x1234 -> dout=0x1234 valid, level=0, udf=0.
- Reset mid-operation: level=3, assert rst_n=0 together with push=1 -> level=0, dout=0, dout_valid=0, flags=0; following pop -> udf=1.
- Non-power-of-two (DEPTH=5): push 5 words -> full=1, level=5; sixth push -> ovf=1; pop 5 -> LIFO order preserved; level never exceeds 5 or goes negative.

Source files
------------

// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO operand stack with registered pop output,
// level/full/empty status, sticky overflow/underflow flags and flush.
//
// Ports:
//   clk        : clock, all state updates on rising edge
//   rst_n      : synchronous active-low reset
//   push       : push request (din onto top of stack)
//   pop        : pop request (top of stack to dout next cycle)
//   flush      : synchronous empty, discards all entries
//   din        : data to push
//   dout       : registered popped word
//   dout_valid : one-cycle strobe after an accepted pop
//   full/empty : decodes of the level register
//   level      : number of valid entries, 0..DEPTH
//   ovf/udf    : sticky overflow / underflow flags
module lifo_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_both;
    logic [LW-1:0]    w_level_m1;
    logic [AW-1:0]    w_top_addr;
    logic [WIDTH-1:0] w_top_data;
    logic             w_we;
    logic [AW-1:0]    w_waddr;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_push_only = push & ~pop;
    assign w_pop_only  = pop & ~push;
    assign w_both      = push & pop;
    assign w_level_m1  = r_level - LW'(1);
    assign w_top_addr  = AW'(w_level_m1);
    // Only consumed when the stack is non-empty, so the address is in range.
    assign w_top_data  = r_mem[w_top_addr];

    // Memory write: append above top, or overwrite top on replace.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_top_addr;
        if (rst_n && !flush) begin
            if (w_push_only && !w_full) begin
                w_we    = 1'b1;
                w_waddr = AW'(r_level);
            end else if (w_both && !w_empty) begin
                w_we    = 1'b1;
                w_waddr = w_top_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (flush) begin
            r_level <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (1'b1)
                w_push_only: begin
                    if (w_full) r_ovf <= 1'b1;
                    else        r_level <= r_level + LW'(1);
                end
                w_pop_only: begin
                    if (w_empty) begin
                        r_udf <= 1'b1;
                    end else begin
                        r_dout  <= w_top_data;
                        r_valid <= 1'b1;
                        r_level <= w_level_m1;
                    end
                end
                w_both: begin
                    // Empty stack: the pushed word bypasses straight out.
                    r_dout  <= w_empty ? din : w_top_data;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign full       = w_full;
    assign empty      = w_empty;
    assign level      = r_level;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack.
// Instance a: WIDTH=16, DEPTH=4. Instance b: WIDTH=16, DEPTH=5.
module tb_lifo_stack;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_push, a_pop, a_flush;
    logic [15:0] a_din, a_dout;
    logic        a_valid, a_full, a_empty, a_ovf, a_udf;
    logic [2:0]  a_level;

    logic        b_push, b_pop, b_flush;
    logic [15:0] b_din, b_dout;
    logic        b_valid, b_full, b_empty, b_ovf, b_udf;
    logic [2:0]  b_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lifo_stack #(.WIDTH(16), .DEPTH(4)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (a_push),
        .pop        (a_pop),
        .flush      (a_flush),
        .din        (a_din),
        .dout       (a_dout),
        .dout_valid (a_valid),
        .full       (a_full),
        .empty      (a_empty),
        .level      (a_level),
        .ovf        (a_ovf),
        .udf        (a_udf)
    );

    lifo_stack #(.WIDTH(16), .DEPTH(5)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (b_push),
        .pop        (b_pop),
        .flush      (b_flush),
        .din        (b_din),
        .dout       (b_dout),
        .dout_valid (b_valid),
        .full       (b_full),
        .empty      (b_empty),
        .level      (b_level),
        .ovf        (b_ovf),
        .udf        (b_udf)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_push  = 1'b0;
        a_pop   = 1'b0;
        a_flush = 1'b0;
    endtask

    task automatic a_do_push(input logic [15:0] d);
        a_push = 1'b1;
        a_pop  = 1'b0;
        a_din  = d;
        step();
        a_idle();
    endtask

    logic [15:0] a_fill [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] b_fill [5] = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05};

    initial begin
        rst_n = 1'b0;
        a_idle();
        a_din = '0;
        b_push = 1'b0; b_pop = 1'b0; b_flush = 1'b0; b_din = '0;
        step();
        step();
        check("rst_level", 32'(a_level), 32'd0);
        check("rst_empty", 32'(a_empty), 32'd1);
        check("rst_full",  32'(a_full),  32'd0);
        check("rst_dout",  32'(a_dout),  32'h0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_flags", 32'({a_ovf, a_udf}), 32'd0);
        rst_n = 1'b1;

        // fill
        for (int i = 0; i < 4; i++) a_do_push(a_fill[i]);
        check("fill_level", 32'(a_level), 32'd4);
        check("fill_full",  32'(a_full),  32'd1);
        check("fill_empty", 32'(a_empty), 32'd0);
        check("fill_ovf",   32'(a_ovf),   32'd0);
        check("fill_valid", 32'(a_valid), 32'd0);

        // back-to-back pops
        for (int i = 3; i >= 0; i--) begin
            a_pop = 1'b1;
            step();
            check("pop_dout",  32'(a_dout),  32'(a_fill[i]));
            check("pop_valid", 32'(a_valid), 32'd1);
            check("pop_level", 32'(a_level), 32'(i));
        end
        a_idle();
        step();
        check("pop_valid_drop", 32'(a_valid), 32'd0);
        check("pop_empty",      32'(a_empty), 32'd1);
        check("pop_dout_hold",  32'(a_dout),  32'h1111);

        // overflow
        for (int i = 0; i < 4; i++) a_do_push(a_fill[i]);
        a_do_push(16'h5555);
        check("ovf_flag",  32'(a_ovf),   32'd1);
        check("ovf_level", 32'(a_level), 32'd4);
        a_pop = 1'b1;
        step();
        a_idle();
        check("ovf_top", 32'(a_dout), 32'h4444);
        check("ovf_sticky", 32'(a_ovf), 32'd1);

        // flush
        a_flush = 1'b1;
        a_push  = 1'b1;
        a_din   = 16'hDEAD;
        step();
        a_idle();
        check("flush_level", 32'(a_level), 32'd0);
        check("flush_ovf",   32'(a_ovf),   32'd0);
        check("flush_valid", 32'(a_valid), 32'd0);
        check("flush_dout",  32'(a_dout),  32'h4444);

        // underflow
        a_pop = 1'b1;
        step();
        a_idle();
        check("udf_flag",  32'(a_udf),   32'd1);
        check("udf_valid", 32'(a_valid), 32'd0);
        check("udf_dout",  32'(a_dout),  32'h4444);
        check("udf_level", 32'(a_level), 32'd0);

        // replace-top
        a_flush = 1'b1;
        step();
        a_idle();
        check("flush_udf", 32'(a_udf), 32'd0);
        a_do_push(16'hAAAA);
        a_do_push(16'hBBBB);
        a_push = 1'b1; a_pop = 1'b1; a_din = 16'hCCCC;
        step();
        a_idle();
        check("rep_dout",  32'(a_dout),  32'hBBBB);
        check("rep_valid", 32'(a_valid), 32'd1);
        check("rep_level", 32'(a_level), 32'd2);
        a_pop = 1'b1;
        step();
        check("rep_pop1", 32'(a_dout), 32'hCCCC);
        step();
        a_idle();
        check("rep_pop2", 32'(a_dout), 32'hAAAA);
        check("rep_empty", 32'(a_empty), 32'd1);

        // bypass on empty
        a_push = 1'b1; a_pop = 1'b1; a_din = 16'h1234;
        step();
        a_idle();
        check("byp_dout",  32'(a_dout),  32'h1234);
        check("byp_valid", 32'(a_valid), 32'd1);
        check("byp_level", 32'(a_level), 32'd0);
        check("byp_udf",   32'(a_udf),   32'd0);

        // reset mid-operation
        a_do_push(16'h0001);
        a_do_push(16'h0002);
        a_do_push(16'h0003);
        check("mid_level", 32'(a_level), 32'd3);
        a_do_push(16'h0004);
        a_do_push(16'h0005);
        check("mid_ovf_pre", 32'(a_ovf), 32'd1);
        a_pop = 1'b1;
        step();
        a_idle();
        check("mid_pop", 32'(a_dout), 32'h0004);
        rst_n  = 1'b0;
        a_push = 1'b1;
        a_din  = 16'h7777;
        step();
        rst_n = 1'b1;
        a_idle();
        check("rrst_level", 32'(a_level), 32'd0);
        check("rrst_dout",  32'(a_dout),  32'h0);
        check("rrst_valid", 32'(a_valid), 32'd0);
        check("rrst_flags", 32'({a_ovf, a_udf}), 32'd0);
        a_pop = 1'b1;
        step();
        a_idle();
        check("rrst_udf",   32'(a_udf),   32'd1);
        check("rrst_pvld",  32'(a_valid), 32'd0);

        // DEPTH=5 instance
        for (int i = 0; i < 5; i++) begin
            b_push = 1'b1; b_din = b_fill[i];
            step();
            check("b_fill_level", 32'(b_level), 32'(i + 1));
        end
        check("b_full", 32'(b_full), 32'd1);
        b_din = 16'h0BAD;
        step();
        b_push = 1'b0;
        check("b_ovf",   32'(b_ovf),   32'd1);
        check("b_level", 32'(b_level), 32'd5);
        for (int i = 4; i >= 0; i--) begin
            b_pop = 1'b1;
            step();
            check("b_pop_dout",  32'(b_dout),  32'(b_fill[i]));
            check("b_pop_level", 32'(b_level), 32'(i));
        end
        step();
        b_pop = 1'b0;
        check("b_udf",    32'(b_udf),   32'd1);
        check("b_floor",  32'(b_level), 32'd0);
        check("b_empty",  32'(b_empty), 32'd1);
        check("b_nvalid", 32'(b_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
